// File: rtl/display_mode_sequencer_if.sv
// Converter handshake between the display mode sequencer and the
// dual-to-ASCII converter: conv_start/conv_valid, disp_load, conv_error.
interface display_mode_sequencer_if;
    logic conv_start;
    logic conv_valid;
    logic disp_load;
    logic conv_error;

    modport master (
        output conv_start,
        output disp_load,
        output conv_error,
        input  conv_valid
    );

    modport slave (
        input  conv_start,
        input  disp_load,
        input  conv_error,
        output conv_valid
    );
endinterface

// File: rtl/display_mode_sequencer.sv
// Bike computer display mode sequencer: short/long press mode stepping,
// overspeed blink with hysteresis, converter start/valid handshake.
// Ports: clock, reset_n, mode_btn, half_sec_pulse, sec_pulse, speed in;
//   mode_onehot, indicator, overspeed, clear_req, clear_mode, col, point
//   out; conv (master): conv_start, disp_load, conv_error out, conv_valid in.
// Optional macro AUTO_SCROLL_EN: advance mode after AUTO_SCROLL_SECS idle.
module display_mode_sequencer #(
    parameter int NUM_MODES           = 4,
    parameter int SPEED_W             = 7,
    parameter int OVERSPEED_THR       = 65,
    parameter int OVERSPEED_HYST      = 3,
    parameter int LONG_PRESS_HALFSECS = 6,
    parameter int CONV_TIMEOUT        = 255,
    parameter logic [NUM_MODES-1:0] COL_MASK   = 4'b0100,
    parameter logic [NUM_MODES-1:0] POINT_MASK = 4'b0011,
    parameter int AUTO_SCROLL_SECS    = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 mode_btn,
    input  logic                 half_sec_pulse,
    input  logic                 sec_pulse,
    input  logic [SPEED_W-1:0]   speed,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic [NUM_MODES-1:0] indicator,
    output logic                 overspeed,
    output logic                 clear_req,
    output logic [NUM_MODES-1:0] clear_mode,
    output logic                 col,
    output logic                 point,
    display_mode_sequencer_if.master conv
);

    localparam int IDX_W  = $clog2(NUM_MODES);
    localparam int HOLD_W = $clog2(LONG_PRESS_HALFSECS + 1);
    localparam int TMR_W  = $clog2(CONV_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_HALFSECS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_HALFSECS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CONV_TIMEOUT - 1);
    localparam logic [SPEED_W-1:0] THR_HI   = SPEED_W'(OVERSPEED_THR);
    localparam logic [SPEED_W-1:0] THR_LO   =
        SPEED_W'(OVERSPEED_THR - OVERSPEED_HYST);
    localparam logic [NUM_MODES-1:0] MODE0  = NUM_MODES'(1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } conv_state_t;

    logic                  btn_r;
    logic                  rel_edge;
    logic                  hold_tick;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  long_q;
    logic                  adv;
    logic                  auto_adv;
    logic                  mode_chg_q;
    logic [NUM_MODES-1:0]  mode_rot;
    logic [IDX_W-1:0]      mode_idx;
    logic                  toggle;
    logic                  trigger;
    conv_state_t           state;
    logic [TMR_W-1:0]      timer;
    logic                  pending;
    logic                  pend_sec;
    logic                  entry;

    assign rel_edge  = btn_r & ~mode_btn;
    // Counting only while both the registered and live level are high
    // keeps a release cycle from sneaking in one more half-second.
    assign hold_tick = btn_r & mode_btn & half_sec_pulse &
                       (hold_cnt != HOLD_MAX);
    assign mode_rot  = {mode_onehot[NUM_MODES-2:0],
                        mode_onehot[NUM_MODES-1]};
    assign adv       = (rel_edge & ~long_q) | auto_adv;
    assign trigger   = sec_pulse | mode_chg_q | clear_req;

    always_comb begin
        mode_idx = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_onehot[i]) begin
                mode_idx = IDX_W'(i);
            end
        end
    end

`ifdef AUTO_SCROLL_EN
    localparam int AS_W = $clog2(AUTO_SCROLL_SECS + 1);
    localparam logic [AS_W-1:0] AS_LAST = AS_W'(AUTO_SCROLL_SECS - 1);

    logic            press_edge;
    logic            as_clr;
    logic [AS_W-1:0] idle_secs;

    assign press_edge = ~btn_r & mode_btn;
    assign as_clr     = press_edge | rel_edge | clear_req;
    // The count keeps running during overspeed; only the advance is held.
    assign auto_adv   = sec_pulse & ~as_clr & ~btn_r & ~overspeed &
                        (idle_secs == AS_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_secs <= '0;
        end else if (as_clr) begin
            idle_secs <= '0;
        end else if (sec_pulse) begin
            if (idle_secs == AS_LAST) begin
                idle_secs <= '0;
            end else begin
                idle_secs <= idle_secs + 1'b1;
            end
        end
    end
`else
    assign auto_adv = 1'b0;
`endif

    // Button: press timing and long-press clear request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_r      <= 1'b0;
            hold_cnt   <= '0;
            long_q     <= 1'b0;
            clear_req  <= 1'b0;
            clear_mode <= '0;
        end else begin
            btn_r     <= mode_btn;
            clear_req <= 1'b0;
            if (rel_edge) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else if (hold_tick) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    clear_req  <= 1'b1;
                    clear_mode <= mode_onehot;
                    long_q     <= 1'b1;
                end
            end
        end
    end

    // Mode selection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_onehot <= MODE0;
            mode_chg_q  <= 1'b0;
        end else begin
            mode_chg_q <= adv;
            if (adv) begin
                mode_onehot <= mode_rot;
            end
        end
    end

    // Overspeed with hysteresis, blink toggle, indicator segments
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overspeed <= 1'b0;
            toggle    <= 1'b0;
            indicator <= '0;
        end else begin
            if (speed > THR_HI) begin
                overspeed <= 1'b1;
            end else if (speed < THR_LO) begin
                overspeed <= 1'b0;
            end
            if (!overspeed) begin
                toggle <= 1'b0;
            end else if (half_sec_pulse) begin
                toggle <= ~toggle;
            end
            indicator <= mode_onehot |
                         ({NUM_MODES{overspeed & toggle}} & ~mode_onehot);
        end
    end

    // Converter handshake; also owns col/point, which change on a start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            timer           <= '0;
            pending         <= 1'b0;
            pend_sec        <= 1'b0;
            entry           <= 1'b0;
            conv.conv_start <= 1'b0;
            conv.disp_load  <= 1'b0;
            conv.conv_error <= 1'b0;
            col             <= 1'b0;
            point           <= 1'b0;
        end else begin
            conv.conv_start <= 1'b0;
            conv.disp_load  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        conv.conv_start <= 1'b1;
                        pending         <= 1'b0;
                        pend_sec        <= 1'b0;
                        entry           <= 1'b0;
                        timer           <= '0;
                        state           <= WAIT;
                        point           <= POINT_MASK[mode_idx];
                        if (!COL_MASK[mode_idx] || entry) begin
                            col <= 1'b0;
                        end else if (sec_pulse || pend_sec) begin
                            col <= ~col;
                        end
                    end
                end
                WAIT: begin
                    if (trigger) begin
                        pending <= 1'b1;
                    end
                    if (sec_pulse) begin
                        pend_sec <= 1'b1;
                    end
                    if (conv.conv_valid) begin
                        conv.disp_load <= 1'b1;
                        state          <= IDLE;
                    end else if (timer == TMR_LAST) begin
                        conv.conv_error <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new mode always starts with the colon dark; entry holds
            // that through the first start in the new mode.
            if (adv) begin
                col   <= 1'b0;
                entry <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Self-checking bench for display_mode_sequencer: scoreboard of expected
// mode changes plus directed checks of handshake, overspeed and blink.
module tb_display_mode_sequencer;

    logic       clock;
    logic       reset_n;
    logic       mode_btn;
    logic       half_sec_pulse;
    logic       sec_pulse;
    logic [6:0] speed;
    logic [3:0] mode_onehot;
    logic [3:0] indicator;
    logic       overspeed;
    logic       clear_req;
    logic [3:0] clear_mode;
    logic       col;
    logic       point;

    display_mode_sequencer_if cif();

    display_mode_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mode_btn       (mode_btn),
        .half_sec_pulse (half_sec_pulse),
        .sec_pulse      (sec_pulse),
        .speed          (speed),
        .mode_onehot    (mode_onehot),
        .indicator      (indicator),
        .overspeed      (overspeed),
        .clear_req      (clear_req),
        .clear_mode     (clear_mode),
        .col            (col),
        .point          (point),
        .conv           (cif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Converter model: answers each start after resp_delay cycles
    logic resp_v;
    logic manual_valid;
    bit   resp_en;
    int   resp_delay;
    int   rcnt;

    assign cif.conv_valid = resp_v | manual_valid;

    initial begin
        resp_v = 1'b0;
        rcnt   = 0;
    end

    always @(posedge clock) begin
        #1;
        resp_v = 1'b0;
        if (rcnt == 1) resp_v = 1'b1;
        if (rcnt > 0) rcnt--;
        if (cif.conv_start && resp_en) rcnt = resp_delay;
    end

    // Event monitor and mode scoreboard
    logic [3:0] exp_q[$];
    logic [3:0] prev_mode;
    logic [3:0] clr_seen;
    bit         sb_on;
    int         cyc = 0;
    int         n_start = 0;
    int         n_load = 0;
    int         n_clear = 0;
    int         start_cyc = 0;
    int         load_cyc = 0;

    always @(negedge clock) begin
        cyc++;
        if (cif.conv_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (cif.disp_load) begin
            n_load++;
            load_cyc = cyc;
        end
        if (clear_req) begin
            n_clear++;
            clr_seen = clear_mode;
        end
        if (sb_on && mode_onehot != prev_mode) begin
            if (exp_q.size() == 0) begin
                check("mode_unexpected", {28'd0, mode_onehot},
                      {28'd0, prev_mode});
            end else begin
                check("mode_sb", {28'd0, mode_onehot},
                      {28'd0, exp_q.pop_front()});
            end
        end
        prev_mode = mode_onehot;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic half_pulse();
        half_sec_pulse = 1'b1;
        tick();
        half_sec_pulse = 1'b0;
        tick();
    endtask

    task automatic sec_strobe();
        sec_pulse = 1'b1;
        tick();
        sec_pulse = 1'b0;
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] m);
        return {m[2:0], m[3]};
    endfunction

    logic [3:0] model_mode;

    task automatic short_press(input logic exp_point);
        int s0;
        s0 = n_start;
        mode_btn = 1'b1;
        tick();
        half_pulse();
        half_pulse();
        model_mode = rotl(model_mode);
        exp_q.push_back(model_mode);
        mode_btn = 1'b0;
        tick(12);
        check("press_start_cnt", n_start - s0, 1);
        check("press_point", {31'd0, point}, {31'd0, exp_point});
        check("press_indicator", {28'd0, indicator}, {28'd0, model_mode});
    endtask

    int s0;
    int l0;
    int c0;

    initial begin
        reset_n        = 1'b0;
        mode_btn       = 1'b0;
        half_sec_pulse = 1'b0;
        sec_pulse      = 1'b0;
        speed          = '0;
        manual_valid   = 1'b0;
        resp_en        = 1'b0;
        resp_delay     = 3;
        sb_on          = 1'b0;
        model_mode     = 4'b0001;
        tick(3);

        check("rst_mode", {28'd0, mode_onehot}, 32'h1);
        check("rst_indicator", {28'd0, indicator}, 32'h0);
        check("rst_overspeed", {31'd0, overspeed}, 32'h0);
        check("rst_conv_start", {31'd0, cif.conv_start}, 32'h0);
        check("rst_conv_error", {31'd0, cif.conv_error}, 32'h0);
        check("rst_col_point", {30'd0, col, point}, 32'h0);

        // Start a conversion, reset while WAITing, then a late valid
        reset_n = 1'b1;
        tick(2);
        sec_strobe();
        check("idle_latency", {31'd0, cif.conv_start}, 32'h1);
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("midwait_rst_mode", {28'd0, mode_onehot}, 32'h1);
        check("midwait_rst_start", {31'd0, cif.conv_start}, 32'h0);
        check("midwait_rst_error", {31'd0, cif.conv_error}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        l0 = n_load;
        manual_valid = 1'b1;
        tick();
        manual_valid = 1'b0;
        tick(5);
        check("late_valid_no_load", n_load - l0, 0);

        // Short presses walk the modes round the ring
        resp_en   = 1'b1;
        prev_mode = mode_onehot;
        sb_on     = 1'b1;
        short_press(1'b1);
        short_press(1'b0);
        short_press(1'b0);
        short_press(1'b1);
        check("sb_drained_4", exp_q.size(), 0);

        // Long press in mode 2
        short_press(1'b1);
        short_press(1'b0);
        s0 = n_start;
        c0 = n_clear;
        mode_btn = 1'b1;
        tick();
        repeat (6) half_pulse();
        tick(2);
        check("long_clear_cnt", n_clear - c0, 1);
        check("long_clear_mode", {28'd0, clr_seen}, 32'h4);
        mode_btn = 1'b0;
        tick(10);
        check("long_no_advance", {28'd0, mode_onehot}, 32'h4);
        check("long_start_cnt", n_start - s0, 1);

        // Colon toggles on sec_pulse starts in mode 2
        check("col_entry", {31'd0, col}, 32'h0);
        sec_strobe();
        tick(6);
        check("col_sec1", {31'd0, col}, 32'h1);
        sec_strobe();
        tick(6);
        check("col_sec2", {31'd0, col}, 32'h0);
        short_press(1'b0);
        check("col_mode3", {31'd0, col}, 32'h0);
        short_press(1'b1);
        check("sb_drained_all", exp_q.size(), 0);

        // Overspeed hysteresis and blink in mode 0
        speed = 7'd60;
        tick(3);
        check("ovs_60", {31'd0, overspeed}, 32'h0);
        speed = 7'd66;
        tick(3);
        check("ovs_66", {31'd0, overspeed}, 32'h1);
        speed = 7'd63;
        tick(3);
        check("ovs_63", {31'd0, overspeed}, 32'h1);
        check("blink_0", {28'd0, indicator}, 32'h1);
        half_pulse();
        tick();
        check("blink_1", {28'd0, indicator}, 32'hF);
        half_pulse();
        tick();
        check("blink_2", {28'd0, indicator}, 32'h1);
        half_pulse();
        tick();
        check("blink_3", {28'd0, indicator}, 32'hF);
        speed = 7'd61;
        tick(3);
        check("ovs_61", {31'd0, overspeed}, 32'h0);
        check("blink_off", {28'd0, indicator}, 32'h1);
        speed = '0;

        // sec_pulse during WAIT merges into one pending start
        resp_delay = 10;
        s0 = n_start;
        l0 = n_load;
        sec_strobe();
        check("pend_first_start", {31'd0, cif.conv_start}, 32'h1);
        tick(3);
        sec_strobe();
        for (int i = 0; i < 30 && n_load == l0; i++) tick();
        tick(3);
        check("pend_load_seen", n_load - l0, 1);
        check("pend_start_cnt", n_start - s0, 2);
        check("pend_start_after_load", start_cyc - load_cyc, 1);
        tick(20);
        check("pend_no_third", n_start - s0, 2);
        check("pend_load_cnt", n_load - l0, 2);

        // Timeout when the converter never answers
        resp_en = 1'b0;
        l0 = n_load;
        sec_strobe();
        check("to_start", {31'd0, cif.conv_start}, 32'h1);
        tick(256);
        check("to_error", {31'd0, cif.conv_error}, 32'h1);
        check("to_no_load", n_load - l0, 0);
        resp_en    = 1'b1;
        resp_delay = 3;
        sec_strobe();
        check("to_restart", {31'd0, cif.conv_start}, 32'h1);
        tick(8);
        check("to_error_sticky", {31'd0, cif.conv_error}, 32'h1);
        check("to_mode_kept", {28'd0, mode_onehot}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_mode_sequencer.md
Name: display_mode_sequencer

Overview:
- Parametrised next-generation display controller for the bike computer.
- Sequences NUM_MODES one-hot display modes from a mode button, distinguishing short presses from long presses.
- Blinks the non-selected mode indicators while overspeed is active, with hysteresis on the threshold.
- Drives the start/valid handshake to the dual-to-ASCII converter, with pending-request merge and a timeout.

Parameters:
- NUM_MODES, 4, number of display modes (2..8); mode 0 is the power-up mode.
- SPEED_W, 7, width of speed input.
- OVERSPEED_THR, 65, overspeed asserts when speed > this value.
- OVERSPEED_HYST, 3, overspeed deasserts when speed < OVERSPEED_THR-OVERSPEED_HYST.
- LONG_PRESS_HALFSECS, 6, number of half_sec_pulse events while held that makes a press long.
- CONV_TIMEOUT, 255, clock cycles in WAIT before the converter is declared hung.
- COL_MASK, 4'b0100, per-mode enable for a blinking colon.
- POINT_MASK, 4'b0011, per-mode decimal point.
- AUTO_SCROLL_SECS, 5, seconds of inactivity before auto-advance (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- mode_btn  in  1  debounced, clock-synchronous button level.
- half_sec_pulse  in  1  1-cycle strobe every 0.5 s.
- sec_pulse  in  1  1-cycle strobe every 1 s.
- speed  in  SPEED_W  current speed.
- conv_valid  in  1  converter result ready, 1-cycle pulse.
- mode_onehot  out  NUM_MODES  selected mode.
- indicator  out  NUM_MODES  LCD mode indicator segments.
- overspeed  out  1  hysteresis overspeed flag.
- clear_req  out  1  1-cycle pulse on long press.
- clear_mode  out  NUM_MODES  mode being cleared; valid with clear_req.
- conv_start  out  1  1-cycle converter start.
- disp_load  out  1  1-cycle strobe to latch converter outputs.
- col  out  1  colon segment.
- point  out  1  decimal point segment.
- conv_error  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs and internal state are cleared asynchronously while reset_n=0, except mode_onehot, which resets to 1 (mode 0). "Cleared" covers indicator, overspeed, blink toggle, hold counter, pending flag, col, point, conv_error, and converter FSM=IDLE.
- Button press detection:
  - btn_r registers mode_btn. A press starts on a 0->1 edge.
  - While held, the hold counter increments on each half_sec_pulse, saturating at LONG_PRESS_HALFSECS.
  - When the counter reaches LONG_PRESS_HALFSECS: clear_req=1 for one cycle and clear_mode=mode_onehot. The press is marked long.
- Mode advance:
  - On release (1->0 edge) of a press not marked long, mode_onehot rotates left one cycle later.
  - Bit NUM_MODES-1 wraps to bit 0.
  - A long press never advances the mode. The hold counter clears on release.
- Overspeed (registered):
  - Set when speed > OVERSPEED_THR.
  - Cleared when speed < OVERSPEED_THR-OVERSPEED_HYST.
  - Held otherwise.
- Blink:
  - The toggle flips on each half_sec_pulse while overspeed=1.
  - The toggle is forced to 0 while overspeed=0.
- indicator (registered) = mode_onehot | ({NUM_MODES{overspeed & toggle}} & ~mode_onehot).
- Refresh trigger: any of sec_pulse, a mode change (the cycle after mode_onehot updates), or clear_req. Simultaneous triggers merge into one.
- Converter FSM states: IDLE, WAIT.
  - IDLE, on trigger or pending=1: conv_start=1 for one cycle; pending cleared; go to WAIT. point and col update on the same edge.
  - WAIT, on conv_valid: disp_load=1 on the next cycle; go to IDLE.
  - WAIT, trigger: sets pending. At most one pending request is held.
  - WAIT timeout: if CONV_TIMEOUT cycles elapse without conv_valid, conv_error is set (sticky until reset) and the FSM returns to IDLE. No disp_load is issued.
  - conv_valid in IDLE is ignored.
- point = POINT_MASK[selected index].
- col:
  - In modes with COL_MASK set, col toggles on each sec_pulse-driven start.
  - col clears to 0 on entry to any mode.
  - col = 0 in modes without COL_MASK set.
- Timing: latency from trigger to conv_start is 1 cycle when idle.

Optional Feature:
- Macro AUTO_SCROLL_EN.
- Defined:
  - An inactivity counter counts sec_pulse events, and is reset by any button edge or clear_req.
  - On reaching AUTO_SCROLL_SECS, the mode advances exactly as a short press would, and the counter restarts.
  - Auto-scroll is suppressed while overspeed=1.
- Undefined: the counter logic is absent and mode changes only by button.

Test Plan:
- Reset with reset_n=0 mid-WAIT -> mode_onehot=4'b0001, conv_start=0, conv_error=0 immediately. After release, no disp_load from a late conv_valid.
- Four short presses (held 2 half-secs each) -> mode_onehot sequence 0010, 0100, 1000, 0001. Each change produces one conv_start.
- Hold in mode 2 for 6 half_sec_pulses -> one clear_req with clear_mode=0100. Release leaves mode at 0100.
- speed sweep 60->66->63->61 -> overspeed 0, 1, 1, 0. With overspeed=1, indicator alternates 0001 and 1111 on each half_sec_pulse.
- conv_valid withheld 256 cycles after conv_start -> conv_error=1, FSM back to IDLE. Next sec_pulse issues conv_start.
- sec_pulse during WAIT plus conv_valid 10 cycles later -> disp_load, then conv_start exactly one cycle after returning to IDLE. No second pending start.
